// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle MIPS control unit.
//
// Sequences the shared datapath one state per cycle. It decodes op/funct,
// which the IR holds stable after FETCH, and drives every enable and mux
// select. It is the only source of PC, IR, register file and memory write
// enables.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high; next state is FETCH
//   op         in   6  instr[31:26]
//   funct      in   6  instr[5:0]
//   zero       in   1  ALU zero flag, used in BEQEX
//   pcen       out  1  PC enable = pcwrite | (branch & zero)
//   memwrite   out  1  memory write strobe
//   irwrite    out  1  IR enable
//   regwrite   out  1  regfile write enable
//   iord       out  1  address mux (0 PC, 1 ALUOut)
//   regdst     out  1  write-address mux (0 rt, 1 rd)
//   memtoreg   out  1  write-data mux (0 ALUOut, 1 Data)
//   alusrca    out  1  0 PC, 1 A
//   alusrcb    out  2  00 B, 01 4, 10 ext imm, 11 signext imm sl2
//   extop      out  1  0 signext, 1 zeroext
//   pcsrc      out  2  00 ALU result, 01 ALUOut, 10 jump target
//   alucontrol out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//   state      out  4  current state (debug)
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       extop,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        IWB     = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state;
    state_t nxt_state;

    logic pcwrite;
    logic branch;
    logic memwrite_raw;
    logic irwrite_raw;
    logic regwrite_raw;

    // R-type funct field to ALU operation; unknown functs fall back to add.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_to_alu = ALU_ADD;
            6'b100010: funct_to_alu = ALU_SUB;
            6'b100100: funct_to_alu = ALU_AND;
            6'b100101: funct_to_alu = ALU_OR;
            6'b101010: funct_to_alu = ALU_SLT;
            default:   funct_to_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state    = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        extop        = 1'b0;
        pcsrc        = 2'b00;
        alucontrol   = ALU_ADD;

        case (cur_state)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                nxt_state   = DECODE;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYP:      nxt_state = RTYPEEX;
                    OP_BEQ:       nxt_state = BEQEX;
                    OP_ADDI:      nxt_state = ADDIEX;
                    OP_ORI:       nxt_state = ORIEX;
                    OP_J:         nxt_state = JEX;
                    default:      nxt_state = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord      = 1'b1;
                nxt_state = MEMWB;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_to_alu(funct);
                nxt_state  = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = IWB;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                extop      = 1'b1;
                alucontrol = ALU_OR;
                nxt_state  = IWB;
            end
            IWB: begin
                regwrite_raw = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                // Unreachable codes 13-15: everything low, recover to FETCH.
                alucontrol = 3'b000;
            end
        endcase
    end

    // Write enables are suppressed while reset is held so no datapath state
    // changes even though the other outputs show the FETCH decode.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign memwrite = ~reset & memwrite_raw;
    assign irwrite  = ~reset & irwrite_raw;
    assign regwrite = ~reset & regwrite_raw;
    assign state    = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite;
    logic       iord, regdst, memtoreg, alusrca, extop;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .extop      (extop),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (state !== 4'd0) begin
                failures++;
                $display("FAIL reset_state cyc%0d: got %0d required 0", c, state);
            end
            checks++;
            if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_writes cyc%0d: got %b required 0000", c,
                         {pcen, irwrite, regwrite, memwrite});
            end
            checks++;
            if (alusrcb !== 2'b01) begin
                failures++;
                $display("FAIL reset_alusrcb cyc%0d: got %b required 01", c, alusrcb);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({irwrite, pcen, alusrcb} !== 4'b1101) begin
            failures++;
            $display("FAIL reset_release: got irwrite/pcen/alusrcb=%b required 1101",
                     {irwrite, pcen, alusrcb});
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (state !== exp_st[i]) begin
                failures++;
                $display("FAIL lw_state step%0d: got %0d required %0d", i, state, exp_st[i]);
            end
            checks++;
            if (regwrite !== (i == 4)) begin
                failures++;
                $display("FAIL lw_regwrite step%0d: got %b required %b", i, regwrite, (i == 4));
            end
            if (i == 3) begin
                checks++;
                if (iord !== 1'b1) begin
                    failures++;
                    $display("FAIL lw_iord: got %b required 1", iord);
                end
            end
            if (i == 4) begin
                checks++;
                if ({memtoreg, regdst} !== 2'b10) begin
                    failures++;
                    $display("FAIL lw_wb_mux: got memtoreg/regdst=%b required 10", {memtoreg, regdst});
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_st[i]) begin
                failures++;
                $display("FAIL sw_state step%0d: got %0d required %0d", i, state, exp_st[i]);
            end
            checks++;
            if ({memwrite, regwrite} !== {(i == 3), 1'b0}) begin
                failures++;
                $display("FAIL sw_writes step%0d: got memwrite/regwrite=%b required %b",
                         i, {memwrite, regwrite}, {(i == 3), 1'b0});
            end
            if (i == 3) begin
                checks++;
                if (iord !== 1'b1) begin
                    failures++;
                    $display("FAIL sw_iord: got %b required 1", iord);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [2] = '{6'b100010, 6'b101010};
        logic [2:0] alu [2] = '{3'b110, 3'b111};
        op = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            funct = fn[k];
            tick();  // DECODE
            tick();  // RTYPEEX
            checks++;
            if ({state, alucontrol, alusrca, alusrcb} !== {4'd6, alu[k], 1'b1, 2'b00}) begin
                failures++;
                $display("FAIL rtype_ex funct=%b: got state=%0d alu=%b srca=%b srcb=%b required state=6 alu=%b srca=1 srcb=00",
                         fn[k], state, alucontrol, alusrca, alusrcb, alu[k]);
            end
            tick();  // RTYPEWB
            checks++;
            if ({state, regdst, regwrite, memtoreg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL rtype_wb: got state=%0d regdst=%b regwrite=%b memtoreg=%b required 7 1 1 0",
                         state, regdst, regwrite, memtoreg);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                failures++;
                $display("FAIL rtype_ret: got %0d required 0", state);
            end
        end
    endtask

    task automatic test_beq();
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            tick();  // DECODE
            tick();  // BEQEX
            #1;
            checks++;
            if ({state, pcen, pcsrc, alucontrol} !== {4'd8, z[0], 2'b01, 3'b110}) begin
                failures++;
                $display("FAIL beq_ex zero=%0d: got state=%0d pcen=%b pcsrc=%b alu=%b required state=8 pcen=%0d pcsrc=01 alu=110",
                         z, state, pcen, pcsrc, alucontrol, z);
            end
            checks++;
            if ({regwrite, memwrite, irwrite} !== 3'b000) begin
                failures++;
                $display("FAIL beq_writes: got %b required 000", {regwrite, memwrite, irwrite});
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                failures++;
                $display("FAIL beq_ret zero=%0d: got %0d required 0", z, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_imm_jump_illegal();
        // ori
        op = 6'b001101;
        tick(); tick();
        checks++;
        if ({state, extop, alucontrol, alusrcb} !== {4'd10, 1'b1, 3'b001, 2'b10}) begin
            failures++;
            $display("FAIL ori_ex: got state=%0d extop=%b alu=%b srcb=%b required 10 1 001 10",
                     state, extop, alucontrol, alusrcb);
        end
        tick();
        checks++;
        if ({state, regwrite, regdst, memtoreg} !== {4'd11, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ori_wb: got state=%0d regwrite=%b regdst=%b memtoreg=%b required 11 1 0 0",
                     state, regwrite, regdst, memtoreg);
        end
        // addi, issued back to back
        tick();
        op = 6'b001000;
        tick(); tick();
        checks++;
        if ({state, extop, alucontrol} !== {4'd9, 1'b0, 3'b010}) begin
            failures++;
            $display("FAIL addi_ex: got state=%0d extop=%b alu=%b required 9 0 010",
                     state, extop, alucontrol);
        end
        tick(); tick();
        // j
        op = 6'b000010;
        tick(); tick();
        checks++;
        if ({state, pcsrc, pcen} !== {4'd12, 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL j_ex: got state=%0d pcsrc=%b pcen=%b required 12 10 1", state, pcsrc, pcen);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL j_ret: got %0d required 0", state);
        end
        // illegal opcode
        op = 6'b111111;
        tick();
        checks++;
        if ({state, pcen, irwrite, regwrite, memwrite} !== {4'd1, 4'b0000}) begin
            failures++;
            $display("FAIL illegal_dec: got state=%0d writes=%b required 1 0000",
                     state, {pcen, irwrite, regwrite, memwrite});
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL illegal_ret: got %0d required 0", state);
        end
    endtask

    task automatic test_reset_in_memrd();
        op = 6'b100011;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd3) begin
            failures++;
            $display("FAIL rst_memrd_reach: got %0d required 3", state);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({state, regwrite} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_memrd_abort: got state=%0d regwrite=%b required 0 0", state, regwrite);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({state, regwrite} !== {4'd1, 1'b0}) begin
            failures++;
            $display("FAIL rst_memrd_resume: got state=%0d regwrite=%b required 1 0", state, regwrite);
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_imm_jump_illegal();
        test_reset_in_memrd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
